hs_rx_fifo: RTL

//  Downstream receive stage for the CPU->peripheral 4-phase send/ack link.

---
 rtl/hs_rx_fifo.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hs_rx_fifo.sv
// hs_rx_fifo: receive side of the 4-phase send/ack link, buffering captured
// words in a fall-through FIFO that drains through a valid/ready port.
module hs_rx_fifo #(
  parameter int DATA_W  = 4,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 2,
  parameter int STALL_W = 8
) (
  input  logic               rx_clock,
  input  logic               rx_reset,
  input  logic               rx_send,
  input  logic [DATA_W-1:0]  in_rx_dados,
  output logic               rx_ack,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_dados,
  input  logic               out_ready,
  output logic [ADDR_W:0]    rx_count,
  output logic [STALL_W-1:0] rx_stall
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_LOW = 1'b1} state_t;

  localparam logic [ADDR_W:0]    FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]    CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]    CNT_ZERO  = (ADDR_W+1)'(0);
  localparam logic [ADDR_W-1:0]  PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  PTR_ZERO  = ADDR_W'(0);
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  state_t             state_r, state_nxt_s;
  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [ADDR_W:0]    count_r, count_nxt_s;
  logic               ack_r, ack_nxt_s;
  logic [STALL_W-1:0] stall_r;
  logic               full_s, empty_s, push_s, pop_s, held_off_s;

  // Full is judged on the registered count, so a pop never frees a slot for the same edge.
  assign full_s  = (count_r == FULL_CNT);
  assign empty_s = (count_r == CNT_ZERO);
  assign pop_s   = (!empty_s) && out_ready;

  // Handshake next-state: one write per rx_send pulse, ack held until rx_send falls.
  always_comb begin
    state_nxt_s = state_r;
    ack_nxt_s   = ack_r;
    push_s      = 1'b0;
    held_off_s  = 1'b0;
    case (state_r)
      IDLE: begin
        ack_nxt_s = 1'b0;
        if (rx_send && !full_s) begin
          push_s      = 1'b1;
          ack_nxt_s   = 1'b1;
          state_nxt_s = WAIT_LOW;
        end else if (rx_send) begin
          held_off_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_LOW: begin
        if (!rx_send) begin
          ack_nxt_s   = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          ack_nxt_s   = 1'b1;
          state_nxt_s = WAIT_LOW;
        end
      end
      default: begin
        ack_nxt_s   = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Control registers: FSM, ack, pointers, occupancy and stall counter.
  always_ff @(posedge rx_clock or negedge rx_reset) begin
    if (!rx_reset) begin
      state_r  <= IDLE;
      ack_r    <= 1'b0;
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      stall_r  <= {STALL_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ack_r   <= ack_nxt_s;
      count_r <= count_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (held_off_s && (stall_r != STALL_MAX)) begin
        stall_r <= stall_r + STALL_ONE;
      end
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge rx_clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_rx_dados;
    end
  end

  assign rx_ack    = ack_r;
  assign rx_count  = count_r;
  assign rx_stall  = stall_r;
  assign out_valid = !empty_s;
  assign out_dados = mem_r[rd_ptr_r];

endmodule
